// File: rtl/pic_priority_controller.sv
// 8259-style interrupt sequencer: masks and nests requests against the ISR,
// runs the two-pulse INTA handshake, drives the vector and retires ISR bits.
module pic_priority_controller #(
   parameter int NUM_IR         = 8,
   parameter int SPURIOUS_LEVEL = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_IR-1:0] irr,
   input  logic [NUM_IR-1:0] imr,
   input  logic [4:0]        vector_base,
   input  logic              aeoi,
   input  logic              inta_n,
   input  logic              eoi,
   input  logic              seoi,
   input  logic [2:0]        eoi_level,
   output logic              int_out,
   output logic [NUM_IR-1:0] isr,
   output logic [NUM_IR-1:0] clear_irr,
   output logic [7:0]        data_out,
   output logic              data_oe
);

   localparam int LW = $clog2(NUM_IR);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_ACK1  = 3'd2;
   localparam logic [2:0] S_WAIT2 = 3'd3;
   localparam logic [2:0] S_ACK2  = 3'd4;

   logic [2:0]        state;
   logic [LW-1:0]     level;
   logic              spurious;
   logic              inta_prev;

   logic [NUM_IR-1:0] pending;
   logic [LW-1:0]     winner;
   logic [LW-1:0]     isr_top;
   logic              qualified;
   logic              inta_fall;
   logic              inta_rise;
   logic [NUM_IR-1:0] set_mask;
   logic [NUM_IR-1:0] clr_mask;

   assign inta_fall = inta_prev & ~inta_n;
   assign inta_rise = ~inta_prev & inta_n;

   always_comb begin
      pending = irr & ~imr;
      winner  = '0;
      isr_top = '0;
      // Descending scan leaves the lowest-index (highest priority) bit.
      for (int unsigned i = NUM_IR; i > 0; i--) begin
         if (pending[LW'(i - 1)]) winner = LW'(i - 1);
         if (isr[LW'(i - 1)])     isr_top = LW'(i - 1);
      end
      qualified = (|pending) && ((isr == '0) || (winner < isr_top));
   end

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (state == S_REQ && inta_fall && qualified)
         set_mask = NUM_IR'(1) << winner;
      if (eoi)
         clr_mask = clr_mask | (isr & (~isr + 1'b1));
      if (seoi)
         clr_mask = clr_mask | (NUM_IR'(1) << eoi_level);
      if (state == S_ACK2 && inta_rise && aeoi && !spurious)
         clr_mask = clr_mask | (NUM_IR'(1) << level);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         level     <= '0;
         spurious  <= 1'b0;
         inta_prev <= 1'b1;
         int_out   <= 1'b0;
         isr       <= '0;
         clear_irr <= '0;
         data_out  <= '0;
         data_oe   <= 1'b0;
      end else begin
         inta_prev <= inta_n;
         clear_irr <= '0;
         // A first-INTA set beats an EOI clear landing on the same bit.
         isr       <= (isr & ~clr_mask) | set_mask;
         case (state)
            S_IDLE: begin
               if (qualified) begin
                  int_out <= 1'b1;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (inta_fall) begin
                  level     <= qualified ? winner : LW'(SPURIOUS_LEVEL);
                  spurious  <= !qualified;
                  clear_irr <= set_mask;
                  int_out   <= 1'b0;
                  state     <= S_ACK1;
               end
            end
            S_ACK1: begin
               if (inta_rise) state <= S_WAIT2;
            end
            S_WAIT2: begin
               if (inta_fall) begin
                  data_out <= {vector_base, level};
                  data_oe  <= 1'b1;
                  state    <= S_ACK2;
               end
            end
            S_ACK2: begin
               if (inta_rise) begin
                  data_out <= '0;
                  data_oe  <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
